instr_fetch_unit: RTL

Instruction fetch and field-split unit for the 16-bit CPU. It executes the fetch-side control strobes (PC load, instruction load, PC increment) issued by the control-signal FSM. It drives the synchronous instruction ROM and latches the returned word into an instruction register or immediate register. It presents opcode and register fields back to the controller and datapath, and assembles 2-byte MVI/LDA instructions.

---
 rtl/instr_fetch_unit.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch and field-split unit: runs PC load / instruction load / PC increment
// strobes against a synchronous ROM and splits the committed word into register fields.
module instr_fetch_unit #(
    parameter int              PC_W     = 8,
    parameter int              DATA_W   = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cs_pc_load,
    input  logic              cs_ins_load,
    input  logic              cs_pc_inc,
    output logic [PC_W-1:0]   rom_addr,
    output logic              rom_rd,
    input  logic [DATA_W-1:0] rom_data,
    output logic [PC_W-1:0]   pc,
    output logic [3:0]        opcode,
    output logic [2:0]        dst_addr,
    output logic [2:0]        src_addr,
    output logic [DATA_W-1:0] imm,
    output logic              ins_valid,
    output logic              imm_valid,
    output logic              ext_pending,
    output logic              busy,
    output logic              err
);

    typedef enum logic [1:0] {F_IDLE, F_REQ, F_WAIT, F_FULL} fstate_e;

    fstate_e             state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [PC_W-1:0]     addr_q, addr_d;
    logic                rd_q, rd_d;
    logic [DATA_W-1:0]   fbuf_q, fbuf_d;
    logic [9:0]          ir_q, ir_d;     // only the opcode/dst/src bits of IR are ever observed
    logic [DATA_W-1:0]   imm_q, imm_d;
    logic                ins_pend_q, ins_pend_d;
    logic                insv_q, insv_d;
    logic                immv_q, immv_d;
    logic                ext_q, ext_d;
    logic                busy_q, busy_d;
    logic                err_q, err_d;
    logic                commit;
    logic [DATA_W-1:0]   commit_word;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d     = state_q;
        pc_d        = cs_pc_inc ? pc_q + PC_W'(1) : pc_q;
        addr_d      = addr_q;
        fbuf_d      = fbuf_q;
        ir_d        = ir_q;
        imm_d       = imm_q;
        ins_pend_d  = ins_pend_q;
        insv_d      = insv_q;
        immv_d      = immv_q;
        ext_d       = ext_q;
        err_d       = err_q;
        commit      = 1'b0;
        commit_word = fbuf_q;

        unique case (state_q)
            F_IDLE: begin
                if (cs_pc_load) begin
                    state_d    = F_REQ;
                    addr_d     = pc_q;
                    ins_pend_d = cs_ins_load;
                end else if (cs_ins_load) begin
                    err_d = 1'b1;
                end
            end
            F_REQ: begin
                state_d = F_WAIT;
                if (cs_pc_load)  err_d      = 1'b1;
                if (cs_ins_load) ins_pend_d = 1'b1;
            end
            F_WAIT: begin
                if (cs_pc_load) err_d = 1'b1;
                if (ins_pend_q || cs_ins_load) begin
                    commit      = 1'b1;
                    commit_word = rom_data;
                    ins_pend_d  = 1'b0;
                    state_d     = F_IDLE;
                end else begin
                    fbuf_d  = rom_data;
                    state_d = F_FULL;
                end
            end
            F_FULL: begin
                // A simultaneous load/commit retires the buffered word before refetching.
                if (cs_ins_load) begin
                    commit  = 1'b1;
                    state_d = F_IDLE;
                end
                if (cs_pc_load) begin
                    state_d = F_REQ;
                    addr_d  = pc_q;
                end
            end
            default: state_d = F_IDLE;
        endcase

        if (commit) begin
            if (ext_q) begin
                imm_d  = commit_word;
                immv_d = 1'b1;
                ext_d  = 1'b0;
            end else begin
                ir_d   = commit_word[DATA_W-1 -: 10];
                insv_d = 1'b1;
                immv_d = 1'b0;
                ext_d  = (commit_word[DATA_W-1 -: 3] == 3'b110);
            end
        end

        rd_d   = (state_d == F_REQ);
        busy_d = (state_d == F_REQ) || (state_d == F_WAIT) || ins_pend_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so all of them update together.
        if (!rst_n) begin
            state_q    <= F_IDLE;
            pc_q       <= RESET_PC;
            addr_q     <= '0;
            rd_q       <= 1'b0;
            fbuf_q     <= '0;
            ir_q       <= '0;
            imm_q      <= '0;
            ins_pend_q <= 1'b0;
            insv_q     <= 1'b0;
            immv_q     <= 1'b0;
            ext_q      <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            rd_q       <= rd_d;
            fbuf_q     <= fbuf_d;
            ir_q       <= ir_d;
            imm_q      <= imm_d;
            ins_pend_q <= ins_pend_d;
            insv_q     <= insv_d;
            immv_q     <= immv_d;
            ext_q      <= ext_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    assign rom_addr    = addr_q;
    assign rom_rd      = rd_q;
    assign pc          = pc_q;
    assign opcode      = ir_q[9:6];
    assign dst_addr    = ir_q[5:3];
    assign src_addr    = ir_q[2:0];
    assign imm         = imm_q;
    assign ins_valid   = insv_q;
    assign imm_valid   = immv_q;
    assign ext_pending = ext_q;
    assign busy        = busy_q;
    assign err         = err_q;

endmodule
